vc_buffer_array: RTL
====================

// Module: vc_buffer_array
// PURPOSE
// - Router input-port buffer holding NumVC independent virtual-channel FIFOs behind one flit input and one flit output.
// - Per-VC wormhole lock on the input side. Round-robin VC arbitration on the output side, held for a whole packet.
// - Sits between the input link and router control. Next generation of the single-VC buffer: N channels, output arbitration, optional credit return.
// PARAMETERS
// - NumVC      default 2   number of virtual channels (>=2)
// - FlitBuff   default 2   FIFO depth per VC, in flits (>=2)
// - FlitWidth  default 34  flit width; type_f/pkt_size decoded via ravenoc_pkg s_flit_head_data_t
// - VcWidth    localparam  $clog2(NumVC)
// PORTS
// - clk          in   1                    clock
// - arst         in   1                    reset, synchronous, active-high
// - fdata_i      in   FlitWidth            input flit
// - vc_id_i      in   VcWidth              target VC of fdata_i
// - valid_i      in   1                    input flit valid
// - ready_o      out  1                    VC vc_id_i can accept fdata_i this cycle
// - fdata_o      out  FlitWidth            head flit of granted VC
// - vc_id_o      out  VcWidth              granted VC
// - valid_o      out  1                    fdata_o valid
// - ready_i      in   1                    downstream accepts fdata_o
// - ocup_o       out  NumVC*($clog2(FlitBuff)+1)  per-VC occupancy, VC0 in LSBs
// - credit_o     out  NumVC                one-cycle pulse per popped flit (VCB_CREDIT_EN only)
// BEHAVIOUR
// - Reset (clk edge with arst=1):
//   - all FIFOs empty; in_lock[*]=0; out_lock=0; rr_ptr=NumVC-1.
//   - Resulting outputs: valid_o=0, ocup_o=0, credit_o=0.
//   - Reset mid-packet discards all stored flits and locks.
// - Input side, per VC v:
//   - ready_o = ~full[vc_id_i] && !(type_f==HEAD_FLIT && in_lock[vc_id_i]).
//   - Write when valid_i && ready_o.
//   - Lock updates only on accepted flits:
//     - HEAD with pkt_size!=0 sets in_lock[v].
//     - TAIL clears in_lock[v].
//     - HEAD with pkt_size==0 (single-flit packet) leaves in_lock[v] unchanged.
//   - Rejected flits change no state.
// - Output arbitration:
//   - out_lock=0: grant = first non-empty VC searching from rr_ptr+1 modulo NumVC. valid_o = any VC non-empty.
//   - out_lock=1: grant = locked_vc. valid_o = ~empty[locked_vc], even if other VCs hold flits.
//   - fdata_o/vc_id_o are combinational from the granted FIFO head. They are don't-care when valid_o=0.
// - Pop when valid_o && ready_i. On each pop:
//   - rr_ptr <= grant.
//   - popped HEAD with pkt_size!=0: out_lock<=1, locked_vc<=grant.
//   - popped TAIL: out_lock<=0.
// - Latency: accepted flit is visible on fdata_o at the earliest one cycle after acceptance. No combinational valid_i->valid_o path.
// - Simultaneous write and pop on the same VC is allowed:
//   - at full: pop frees a slot next cycle only (ready_o does not look at ready_i);
//   - ocup unchanged.
// - Writes to different VCs never block each other. A full VC only deasserts ready_o for flits addressed to it.
// - NumVC not a power of 2: vc_id_i >= NumVC gives ready_o=0 and no write.
// - FIFO overflow/underflow is impossible by construction. An assertion on FIFO error, guarded by NO_ASSERTIONS, fires if it occurs.
// CONFIGURATION
// - VCB_CREDIT_EN defined:
//   - credit_o[v] = 1 for exactly one cycle, registered, the cycle after each pop from VC v.
//   - This is credit return for upstream flow control.
// - VCB_CREDIT_EN undefined: credit_o is tied to 0 and no credit registers exist.
// TESTING
// - Reset, then one idle cycle -> valid_o=0, ready_o=1 for VC0 and VC1, ocup_o=0.
// - VC0 HEAD(pkt_size=2), BODY, TAIL back-to-back, ready_i=1:
//   - 3 flits out in order on vc_id_o=0, first one cycle after accept;
//   - in_lock[0] returns to 0.
// - VC0 HEAD(pkt_size=1) accepted, then second HEAD to VC0 -> ready_o=0 until TAIL accepted, then second HEAD accepted.
// - VC0 and VC1 each hold a 2-flit packet, ready_i=1:
//   - output is VC0 HEAD, VC0 TAIL, VC1 HEAD, VC1 TAIL;
//   - no VC interleaving inside a packet;
//   - next packets start from VC0 (round-robin).
// - FlitBuff=2, ready_i=0, 3 flits to VC1 -> third sees ready_o=0, ocup VC1=2. Flits to VC0 are still accepted.
// - VCB_CREDIT_EN, 4 pops from VC1 -> exactly 4 single-cycle pulses on credit_o[1], each one cycle after its pop. Reset mid-packet -> valid_o=0 next cycle, locks cleared.

Source files
------------

// File: rtl/vc_buffer_array.sv
// Router input buffer: NumVC virtual-channel FIFOs, per-VC wormhole input lock, packet-held round-robin output.
// Flit head layout: [FW-1:FW-2] type, [FW-3:FW-4] x/y dest, [FW-5 -: 8] pkt_size. VCB_CREDIT_EN enables credit_o.
module vc_buffer_array #(
    parameter int NumVC     = 2,
    parameter int FlitBuff  = 2,
    parameter int FlitWidth = 34,
    localparam int VcWidth  = $clog2(NumVC),
    localparam int CntWidth = $clog2(FlitBuff) + 1
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic [FlitWidth-1:0]      fdata_i,
    input  logic [VcWidth-1:0]        vc_id_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output logic [FlitWidth-1:0]      fdata_o,
    output logic [VcWidth-1:0]        vc_id_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [NumVC*CntWidth-1:0] ocup_o,
    output logic [NumVC-1:0]          credit_o
);

    localparam int PtrWidth   = $clog2(FlitBuff);
    localparam int PktSzWidth = 8;
    localparam int TypeLsb    = FlitWidth - 2;
    localparam int PktSzLsb   = FlitWidth - 4 - PktSzWidth;

    typedef enum logic [1:0] {
        HEAD_FLIT = 2'b00,
        BODY_FLIT = 2'b01,
        TAIL_FLIT = 2'b10
    } flit_type_t;

    logic [FlitWidth-1:0] mem    [NumVC][FlitBuff];
    logic [PtrWidth-1:0]  wr_ptr [NumVC];
    logic [PtrWidth-1:0]  rd_ptr [NumVC];
    logic [CntWidth-1:0]  count  [NumVC];

    logic [NumVC-1:0]     full;
    logic [NumVC-1:0]     empty;
    logic [NumVC-1:0]     wr_en;
    logic [NumVC-1:0]     rd_en;
    logic [NumVC-1:0]     in_lock;

    logic                 out_lock;
    logic [VcWidth-1:0]   locked_vc;
    logic [VcWidth-1:0]   rr_ptr;
    logic [VcWidth-1:0]   grant;
    logic [VcWidth-1:0]   cand;
    logic                 found;

    logic                 vc_ok;
    logic                 accept;
    logic                 pop;
    flit_type_t           in_type;
    flit_type_t           out_type;
    logic                 in_sized;
    logic                 out_sized;
    logic [FlitWidth-1:0] head_flit;

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(FlitBuff - 1)) ? '0 : p + 1'b1;
    endfunction

    generate
        if (NumVC == (1 << VcWidth)) begin : g_vc_pow2
            assign vc_ok = 1'b1;
        end else begin : g_vc_npow2
            assign vc_ok = (vc_id_i < VcWidth'(NumVC));
        end
    endgenerate

    always_comb begin
        in_type  = flit_type_t'(fdata_i[TypeLsb +: 2]);
        in_sized = |fdata_i[PktSzLsb +: PktSzWidth];
        ready_o  = 1'b0;
        if (vc_ok) begin
            ready_o = !full[vc_id_i] && !((in_type == HEAD_FLIT) && in_lock[vc_id_i]);
        end
        accept = valid_i && ready_o;
    end

    always_comb begin
        full  = '0;
        empty = '0;
        wr_en = '0;
        rd_en = '0;
        for (int unsigned v = 0; v < NumVC; v++) begin
            full[v]  = (count[v] == CntWidth'(FlitBuff));
            empty[v] = (count[v] == '0);
            wr_en[v] = accept && (vc_id_i == VcWidth'(v));
            rd_en[v] = pop && (grant == VcWidth'(v));
        end
    end

    // Search starts one past the last served VC; an open packet pins the grant.
    always_comb begin
        grant = rr_ptr;
        cand  = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= NumVC; i++) begin
            cand = VcWidth'((32'(rr_ptr) + i) % 32'(NumVC));
            if (!found && !empty[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
        if (out_lock) begin
            grant = locked_vc;
        end
        valid_o   = out_lock ? !empty[locked_vc] : |(~empty);
        head_flit = mem[grant][rd_ptr[grant]];
        fdata_o   = head_flit;
        vc_id_o   = grant;
        out_type  = flit_type_t'(head_flit[TypeLsb +: 2]);
        out_sized = |head_flit[PktSzLsb +: PktSzWidth];
        pop       = valid_o && ready_i;
    end

    always_comb begin
        ocup_o = '0;
        for (int unsigned v = 0; v < NumVC; v++) begin
            ocup_o[v*CntWidth +: CntWidth] = count[v];
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned v = 0; v < NumVC; v++) begin
            if (wr_en[v]) begin
                mem[v][wr_ptr[v]] <= fdata_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            for (int unsigned v = 0; v < NumVC; v++) begin
                wr_ptr[v]  <= '0;
                rd_ptr[v]  <= '0;
                count[v]   <= '0;
                in_lock[v] <= 1'b0;
            end
        end else begin
            for (int unsigned v = 0; v < NumVC; v++) begin
                if (wr_en[v]) begin
                    wr_ptr[v] <= next_ptr(wr_ptr[v]);
                end
                if (rd_en[v]) begin
                    rd_ptr[v] <= next_ptr(rd_ptr[v]);
                end
                if (wr_en[v] && !rd_en[v]) begin
                    count[v] <= count[v] + 1'b1;
                end else if (!wr_en[v] && rd_en[v]) begin
                    count[v] <= count[v] - 1'b1;
                end
                // Single-flit packets (pkt_size==0) neither open nor close a wormhole.
                if (wr_en[v]) begin
                    if ((in_type == HEAD_FLIT) && in_sized) begin
                        in_lock[v] <= 1'b1;
                    end else if (in_type == TAIL_FLIT) begin
                        in_lock[v] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            out_lock  <= 1'b0;
            locked_vc <= '0;
            rr_ptr    <= VcWidth'(NumVC - 1);
        end else if (pop) begin
            rr_ptr <= grant;
            if ((out_type == HEAD_FLIT) && out_sized) begin
                out_lock  <= 1'b1;
                locked_vc <= grant;
            end else if (out_type == TAIL_FLIT) begin
                out_lock <= 1'b0;
            end
        end
    end

`ifdef VCB_CREDIT_EN
    logic [NumVC-1:0] credit_q;

    always_ff @(posedge clk) begin
        if (arst) begin
            credit_q <= '0;
        end else begin
            credit_q <= rd_en;
        end
    end

    assign credit_o = credit_q;
`else
    assign credit_o = '0;
`endif

`ifndef NO_ASSERTIONS
    logic fifo_err;

    always_comb begin
        fifo_err = |(wr_en & full) || |(rd_en & empty);
    end

    a_fifo_err: assert property (@(posedge clk) disable iff (arst) !fifo_err);
`endif

endmodule
